// File: rtl/rr_packet_arbiter_pkg.sv
// Shared types and mask helpers for the round-robin packet arbiter.
// Helpers work on a fixed MAX_W vector; callers cast to their width.
package rr_arbiter_pkg;

  localparam int MAX_W = 64;
  localparam int PTR_W = $clog2(MAX_W);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic logic [MAX_W-1:0] isolate_lowest(
    input logic [MAX_W-1:0] x
  );
    return x & (-x);
  endfunction

  function automatic logic [MAX_W-1:0] thermo_mask(
    input logic [PTR_W-1:0] p
  );
    return ~((MAX_W'(1) << p) - MAX_W'(1));
  endfunction

endpackage

// File: rtl/rr_packet_arbiter_if.sv
// Requester/output stream bundle of the packet arbiter.
// slave is the arbiter side, master the requester/sink side.
interface rr_packet_arbiter_if #(
  parameter int WIDTH = 16
);
  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0] req_vld;
  logic [WIDTH-1:0] req_lst;
  logic [WIDTH-1:0] req_rdy;
  logic             out_vld;
  logic             out_lst;
  logic             out_rdy;
  logic [IW-1:0]    out_idx;
  logic [WIDTH-1:0] out_gnt;

  modport slave (
    input  req_vld, req_lst, out_rdy,
    output req_rdy, out_vld, out_lst, out_idx, out_gnt
  );

  modport master (
    output req_vld, req_lst, out_rdy,
    input  req_rdy, out_vld, out_lst, out_idx, out_gnt
  );

endinterface

// File: rtl/onehot_encoder_tree.sv
// One-hot to binary index encoder with selectable structure.
// All variants give the same index for a one-hot input.
module onehot_encoder_tree #(
  parameter int WIDTH          = 16,
  parameter int SPLIT          = 4,
  parameter int IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0]         i_gnt,
  output logic [$clog2(WIDTH)-1:0] o_idx,
  output logic                     o_vld
);
  localparam int IW = $clog2(WIDTH);

  assign o_vld = |i_gnt;

  if (IMPLEMENTATION == 1) begin : g_or
    always_comb begin
      o_idx = '0;
      for (int i = 0; i < WIDTH; i++)
        if (i_gnt[i]) o_idx = o_idx | IW'(i);
    end
  end else if (IMPLEMENTATION == 2) begin : g_prio
    always_comb begin
      o_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--)
        if (i_gnt[i]) o_idx = IW'(i);
    end
  end else if (IMPLEMENTATION == 3) begin : g_bits
    always_comb begin
      o_idx = '0;
      for (int b = 0; b < IW; b++)
        for (int i = 0; i < WIDTH; i++)
          if (((i >> b) & 1) == 1)
            o_idx[b] = o_idx[b] | i_gnt[i];
    end
  end else begin : g_tree
    // group base from the hit group, offset from OR of all groups
    localparam int NG = (WIDTH + SPLIT - 1) / SPLIT;
    localparam int PW = NG * SPLIT;
    logic [PW-1:0]    w_pad;
    logic [SPLIT-1:0] w_off_oh;
    logic [IW-1:0]    w_base;
    logic [IW-1:0]    w_off;
    assign w_pad = PW'(i_gnt);
    always_comb begin
      w_base   = '0;
      w_off_oh = '0;
      w_off    = '0;
      for (int g = 0; g < NG; g++)
        if (|w_pad[g*SPLIT +: SPLIT]) begin
          w_base   = IW'(g * SPLIT);
          w_off_oh = w_off_oh | w_pad[g*SPLIT +: SPLIT];
        end
      for (int j = 0; j < SPLIT; j++)
        if (w_off_oh[j]) w_off = IW'(j);
    end
    assign o_idx = w_base + w_off;
  end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: grant locked per packet,
// re-arbitration on the last beat so packets run back to back.
module rr_packet_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int SPLIT          = 4,
  parameter int IMPLEMENTATION = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_packet_arbiter_if.slave  bus
);
  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_gnt;
  logic [IW-1:0]    r_ptr;
  logic [WIDTH-1:0] w_gnt_nxt;
  logic [IW-1:0]    w_ptr_nxt;
  logic [WIDTH-1:0] w_msk;
  logic [WIDTH-1:0] w_sel;
  logic [IW-1:0]    w_sel_idx;
  logic [IW-1:0]    w_ptr_inc;
  logic [IW-1:0]    w_enc_idx;
  logic             w_enc_vld;
  logic             w_trn;
  logic             w_end;
  arb_state_t       w_state;

  assign w_msk = bus.req_vld & WIDTH'(thermo_mask(PTR_W'(r_ptr)));
  assign w_sel = (|w_msk)
    ? WIDTH'(isolate_lowest(MAX_W'(w_msk)))
    : WIDTH'(isolate_lowest(MAX_W'(bus.req_vld)));

  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (w_sel[i]) w_sel_idx = IW'(i);
  end

  // explicit wrap so non power-of-2 widths stay in range
  assign w_ptr_inc = (w_sel_idx == IW'(WIDTH - 1))
    ? '0 : w_sel_idx + IW'(1);

  onehot_encoder_tree #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_enc (
    .i_gnt (r_gnt),
    .o_idx (w_enc_idx),
    .o_vld (w_enc_vld)
  );

  assign w_state     = (|r_gnt) ? BUSY : IDLE;
  assign bus.out_gnt = r_gnt;
  assign bus.out_vld = |(bus.req_vld & r_gnt);
  assign bus.out_lst = |(bus.req_lst & bus.req_vld & r_gnt);
  assign bus.req_rdy = r_gnt & {WIDTH{bus.out_rdy}};
  assign bus.out_idx = w_enc_vld ? w_enc_idx : '0;

  assign w_trn = bus.out_vld & bus.out_rdy;
  assign w_end = w_trn & bus.out_lst;

  always_comb begin
    w_gnt_nxt = r_gnt;
    w_ptr_nxt = r_ptr;
    unique case (w_state)
      IDLE: begin
        if (|w_sel) begin
          w_gnt_nxt = w_sel;
          w_ptr_nxt = w_ptr_inc;
        end
      end
      BUSY: begin
        if (w_end) begin
          w_gnt_nxt = w_sel;
          if (|w_sel) w_ptr_nxt = w_ptr_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt <= '0;
      r_ptr <= '0;
    end else begin
      r_gnt <= w_gnt_nxt;
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter, WIDTH 16 and 5,
// every encoder implementation, against a rotating-search model.
module tb_rr_packet_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] vld;
  logic [15:0] lst;
  logic        rdy;

  logic [15:0] gnt16 [5];
  logic [15:0] rq16  [5];
  logic [3:0]  idx16 [5];
  logic        ov16  [5];
  logic        ol16  [5];
  logic [4:0]  gnt5  [5];
  logic [4:0]  rq5   [5];
  logic [2:0]  idx5  [5];
  logic        ov5   [5];
  logic        ol5   [5];

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] pv, pl, pr;
  int b, acc;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 5; k++) begin : g_w16
    rr_packet_arbiter_if #(.WIDTH(16)) bus ();
    assign bus.req_vld = vld;
    assign bus.req_lst = lst;
    assign bus.out_rdy = rdy;
    assign gnt16[k] = bus.out_gnt;
    assign rq16[k]  = bus.req_rdy;
    assign idx16[k] = bus.out_idx;
    assign ov16[k]  = bus.out_vld;
    assign ol16[k]  = bus.out_lst;
    rr_packet_arbiter #(
      .WIDTH(16), .SPLIT(4), .IMPLEMENTATION(k)
    ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
    );
  end

  for (genvar k = 0; k < 5; k++) begin : g_w5
    rr_packet_arbiter_if #(.WIDTH(5)) bus ();
    assign bus.req_vld = vld[4:0];
    assign bus.req_lst = lst[4:0];
    assign bus.out_rdy = rdy;
    assign gnt5[k] = bus.out_gnt;
    assign rq5[k]  = bus.req_rdy;
    assign idx5[k] = bus.out_idx;
    assign ov5[k]  = bus.out_vld;
    assign ol5[k]  = bus.out_lst;
    rr_packet_arbiter #(
      .WIDTH(5), .SPLIT(4), .IMPLEMENTATION(k)
    ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
    );
  end

  // reference: owner index (-1 idle) and rotating search start
  int m16_own = -1;
  int m16_ptr = 0;
  int m5_own  = -1;
  int m5_ptr  = 0;
  int p16, p5;

  function automatic int pick(input logic [15:0] v,
                              input int p, input int w);
    for (int k = 0; k < w; k++)
      if (v[(p + k) % w]) return (p + k) % w;
    return -1;
  endfunction

  function automatic logic bitof(input logic [15:0] v,
                                 input int o);
    if (o < 0) return 1'b0;
    return v[o];
  endfunction

  function automatic logic [15:0] eg(input int o);
    if (o < 0) return 16'h0;
    return 16'h1 << o;
  endfunction

  function automatic logic fin(input int o,
                               input logic [15:0] v,
                               input logic [15:0] l,
                               input logic r);
    return bitof(v & l, o) & r;
  endfunction

  always_comb p16 = pick(vld, m16_ptr, 16);
  always_comb p5  = pick(vld & 16'h001f, m5_ptr, 5);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m16_own <= -1;
      m16_ptr <= 0;
      m5_own  <= -1;
      m5_ptr  <= 0;
    end else begin
      if (m16_own < 0 || fin(m16_own, vld, lst, rdy)) begin
        m16_own <= p16;
        if (p16 >= 0) m16_ptr <= (p16 + 1) % 16;
      end
      if (m5_own < 0 || fin(m5_own, vld, lst, rdy)) begin
        m5_own <= p5;
        if (p5 >= 0) m5_ptr <= (p5 + 1) % 5;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic settle();
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("w16_i%0d_gnt", k), 32'(gnt16[k]),
            32'(eg(m16_own)));
      check($sformatf("w16_i%0d_idx", k), 32'(idx16[k]),
            (m16_own < 0) ? 0 : m16_own);
      check($sformatf("w16_i%0d_vld", k), 32'(ov16[k]),
            32'(bitof(vld, m16_own)));
      check($sformatf("w16_i%0d_lst", k), 32'(ol16[k]),
            32'(bitof(vld & lst, m16_own)));
      check($sformatf("w16_i%0d_rdy", k), 32'(rq16[k]),
            32'(eg(m16_own) & {16{rdy}}));
      check($sformatf("w5_i%0d_gnt", k), 32'(gnt5[k]),
            32'(eg(m5_own)));
      check($sformatf("w5_i%0d_idx", k), 32'(idx5[k]),
            (m5_own < 0) ? 0 : m5_own);
      check($sformatf("w5_i%0d_vld", k), 32'(ov5[k]),
            32'(bitof(vld, m5_own)));
      check($sformatf("w5_i%0d_lst", k), 32'(ol5[k]),
            32'(bitof(vld & lst, m5_own)));
      check($sformatf("w5_i%0d_rdy", k), 32'(rq5[k]),
            32'(eg(m5_own) & {16{rdy}}));
    end
    for (int i = 0; i < 16; i++)
      if (pv[i] && !pr[i] && vld[i])
        check($sformatf("proto_lst%0d", i), 32'(lst[i]),
              32'(pl[i]));
  endtask

  task automatic adv();
    pv = vld;
    pl = lst;
    pr = rq16[0];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vld   = '0;
    lst   = '0;
    rdy   = 1'b1;
    settle();
    adv();
    rst_n = 1'b1;
  endtask

  initial begin
    pv = '0; pl = '0; pr = '0;
    rst_n = 1'b0;
    vld   = 16'hffff;
    lst   = 16'hffff;
    rdy   = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      settle();
      check("rst_gnt", 32'(gnt16[0]), 0);
      check("rst_vld", 32'(ov16[0]), 0);
      check("rst_rdy", 32'(rq16[0]), 0);
      check("rst_w5_gnt", 32'(gnt5[0]), 0);
      adv();
    end
    rst_n = 1'b1;
    settle();
    check("rst_idle", 32'(gnt16[0]), 0);
    adv();

    // fairness: one-beat packets from everyone
    for (int i = 0; i < 17; i++) begin
      settle();
      check("fair_idx", 32'(idx16[0]), i % 16);
      check("fair_rdy", 32'(rq16[0]), 32'(16'h1 << (i % 16)));
      check("fair_w5_idx", 32'(idx5[0]), i % 5);
      adv();
    end

    // lock: 4-beat packet from 3, 5 joins on beat 2
    do_reset();
    vld = 16'h0008; lst = 16'h0000;
    settle();
    check("lk_idle", 32'(gnt16[0]), 0);
    adv();
    for (int bt = 0; bt < 4; bt++) begin
      vld = (bt >= 1) ? 16'h0028 : 16'h0008;
      lst = (bt == 3) ? 16'h0028 :
            (bt >= 1) ? 16'h0020 : 16'h0000;
      settle();
      check("lk_idx", 32'(idx16[0]), 3);
      check("lk_vld", 32'(ov16[0]), 1);
      check("lk_lst", 32'(ol16[0]), 32'(bt == 3));
      adv();
    end
    vld = 16'h0020; lst = 16'h0020;
    settle();
    check("lk_next_idx", 32'(idx16[0]), 5);
    check("lk_next_rdy", 32'(rq16[0]), 32'h0020);
    adv();

    // backpressure and bubbles on a 6-beat packet from 3
    do_reset();
    b = 0; acc = 0;
    for (int c = 0; c < 40 && b < 6; c++) begin
      rdy    = (c % 2 == 0);
      vld    = '0;
      vld[3] = (c != 3 && c != 4);
      vld[9] = (c >= 2);
      lst    = 16'h0200;
      lst[3] = (b == 5);
      settle();
      if (c >= 1) begin
        check("bp_gnt", 32'(gnt16[0]), 32'h0008);
        check("bp_vld", 32'(ov16[0]), 32'(vld[3]));
      end
      if (ov16[0] && rdy) begin
        check("bp_lst_pos", 32'(ol16[0]), 32'(acc == 5));
        acc++;
      end
      if (vld[3] && rq16[0][3]) b++;
      adv();
    end
    check("bp_beats_out", acc, 6);
    check("bp_beats_sent", b, 6);
    vld = 16'h0200; lst = 16'h0200; rdy = 1'b1;
    settle();
    check("bp_next_idx", 32'(idx16[0]), 9);
    adv();

    // wrap past 15 and sole-requester re-grant
    do_reset();
    vld = 16'h4000; lst = 16'h4000;
    settle();
    adv();
    vld = 16'hc000; lst = 16'hc000;
    settle();
    check("wr_14", 32'(idx16[0]), 14);
    adv();
    vld = 16'h8000; lst = 16'h8000;
    for (int r = 0; r < 3; r++) begin
      settle();
      check("wr_sole15", 32'(idx16[0]), 15);
      adv();
    end
    vld = 16'h8001; lst = 16'h8001;
    settle();
    check("wr_15b", 32'(idx16[0]), 15);
    adv();
    settle();
    check("wr_0wins", 32'(idx16[0]), 0);
    adv();
    settle();
    check("wr_back15", 32'(idx16[0]), 15);
    adv();

    // asynchronous reset during beat 2 of requester 7
    do_reset();
    vld = 16'h0080; lst = 16'h0000;
    settle();
    adv();
    settle();
    check("ar_b1_idx", 32'(idx16[0]), 7);
    adv();
    settle();
    check("ar_b2_idx", 32'(idx16[0]), 7);
    rst_n = 1'b0;
    #1;
    check("ar_gnt", 32'(gnt16[0]), 0);
    check("ar_vld", 32'(ov16[0]), 0);
    check("ar_rdy", 32'(rq16[0]), 0);
    check("ar_idx", 32'(idx16[0]), 0);
    check("ar_w5_gnt", 32'(gnt5[0]), 0);
    adv();
    vld = 16'h0208; lst = 16'h0208;
    rst_n = 1'b1;
    settle();
    check("ar_idle", 32'(gnt16[0]), 0);
    adv();
    settle();
    check("ar_ptr0_idx", 32'(idx16[0]), 3);
    adv();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
